// File: rtl/sram_march_tester.sv
// sram_march_tester: March C- built-in self-test initiator for one SRAM bank.
//
// Runs the six March C- elements over the whole bank, one request per cycle, and
// compares each read against the expected data background one cycle later.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 launch a test (honoured only while idle or done)
//   busy_o                  test in progress; this block owns the bank port
//   done_o, pass_o          test finished / no mismatch seen (valid while done_o)
//   fail_addr_o/elem_o      address and element index of the first mismatch
//   fail_cnt_o              saturating mismatch count
//   sram_*                  bank request port (req/we/addr/wdata/be/retention)
//   sram_rdata_i            read data, valid the cycle after a read request
module sram_march_tester #(
  parameter int unsigned NumWords     = 8192,
  parameter int unsigned AddrWidth    = $clog2(NumWords),
  parameter int unsigned FailCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [AddrWidth-1:0]    fail_addr_o,
  output logic [2:0]              fail_elem_o,
  output logic [FailCntWidth-1:0] fail_cnt_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [AddrWidth-1:0]    sram_addr_o,
  output logic [31:0]             sram_wdata_o,
  output logic [3:0]              sram_be_o,
  output logic                    sram_set_retentive_no,
  input  logic [31:0]             sram_rdata_i
);

  localparam logic [AddrWidth-1:0]    LastAddr = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0]    AddrOne  = AddrWidth'(1);
  localparam logic [FailCntWidth-1:0] CntOne   = FailCntWidth'(1);
  localparam logic [FailCntWidth-1:0] CntMax   = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  // RUN sub-state: element index, read/write phase, address
  logic [2:0]              elem_q, elem_d;
  logic                    wr_q, wr_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;

  // Compare pipeline stage for the read issued last cycle
  logic                    cmp_valid_q, cmp_valid_d;
  logic [31:0]             cmp_exp_q, cmp_exp_d;
  logic [AddrWidth-1:0]    cmp_addr_q, cmp_addr_d;
  logic [2:0]              cmp_elem_q, cmp_elem_d;

  // Result registers
  logic [FailCntWidth-1:0] fail_cnt_q, fail_cnt_d;
  logic [AddrWidth-1:0]    fail_addr_q, fail_addr_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;

  logic                    launch;
  logic                    down;
  logic                    at_end;
  logic                    addr_done;
  logic                    elem_done;
  logic                    mismatch;
  logic [31:0]             rd_exp;
  logic [31:0]             wr_val;

  // Element decode: E3/E4 descend; E2/E4 read ones; E1/E3 write ones.
  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign at_end    = down ? (addr_q == '0) : (addr_q == LastAddr);
  // E0 and E5 are single-op elements; otherwise the write closes the address.
  assign addr_done = (elem_q == 3'd0) || (elem_q == 3'd5) || wr_q;
  assign elem_done = addr_done && at_end;
  assign rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
  assign wr_val    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
  assign mismatch  = cmp_valid_q && (|(sram_rdata_i ^ cmp_exp_q));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          launch  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (elem_done && (elem_q == 3'd5)) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o       = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    unique case (state_q)
      StRun: begin
        busy_o       = 1'b1;
        sram_req_o   = 1'b1;
        sram_we_o    = wr_q;
        sram_addr_o  = addr_q;
        sram_wdata_o = wr_val;
      end
      StDrain: busy_o = 1'b1;
      default: ;
    endcase
  end

  assign sram_be_o             = 4'hF;
  assign sram_set_retentive_no = 1'b1;
  assign done_o                = done_q;
  assign pass_o                = pass_q;
  assign fail_cnt_o            = fail_cnt_q;
  assign fail_addr_o           = fail_addr_q;
  assign fail_elem_o           = fail_elem_q;

  // ---------------------------------------------------------------------------
  // Sequencer and compare datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    elem_d = elem_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    if (launch) begin
      elem_d = 3'd0;
      wr_d   = 1'b1;
      addr_d = '0;
    end else if (state_q == StRun) begin
      if (elem_done) begin
        if (elem_q != 3'd5) begin
          elem_d = elem_q + 3'd1;
          wr_d   = 1'b0;
          // Elements after E2 and E3 are the descending ones.
          addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LastAddr : '0;
        end
      end else if (addr_done) begin
        wr_d   = (elem_q == 3'd0);
        addr_d = down ? (addr_q - AddrOne) : (addr_q + AddrOne);
      end else begin
        wr_d = 1'b1;
      end
    end
  end

  always_comb begin
    cmp_valid_d = (state_q == StRun) && !wr_q;
    cmp_exp_d   = rd_exp;
    cmp_addr_d  = addr_q;
    cmp_elem_d  = elem_q;
  end

  always_comb begin
    fail_cnt_d  = fail_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    done_d      = done_q;
    pass_d      = pass_q;
    if (launch) begin
      fail_cnt_d  = '0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
    end else begin
      if (mismatch) begin
        if (fail_cnt_q != CntMax) begin
          fail_cnt_d = fail_cnt_q + CntOne;
        end
        // Count never wraps back to zero, so zero means "no mismatch yet".
        if (fail_cnt_q == '0) begin
          fail_addr_d = cmp_addr_q;
          fail_elem_d = cmp_elem_q;
        end
      end
      // DRAIN folds in the final E5 read before the verdict is latched.
      if (state_q == StDrain) begin
        done_d = 1'b1;
        pass_d = (fail_cnt_d == '0);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      elem_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      fail_cnt_q  <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      elem_q      <= elem_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

endmodule

// File: tb/tb_sram_march_tester.sv
// Testbench for sram_march_tester with NumWords=16. Two instances share one
// behavioural 1-cycle-latency SRAM with per-word stuck-at-0 masks: "a" uses the
// default 16-bit counter, "b" a 4-bit counter. sel picks which one owns the SRAM.
module tb_sram_march_tester;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, sel;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  logic        a_busy, a_done, a_pass, a_req, a_we, a_ret;
  logic [3:0]  a_fail_addr, a_addr, a_be;
  logic [2:0]  a_fail_elem;
  logic [15:0] a_fail_cnt;
  logic [31:0] a_wdata;

  logic        b_busy, b_done, b_pass, b_req, b_we, b_ret;
  logic [3:0]  b_fail_addr, b_addr, b_be;
  logic [2:0]  b_fail_elem;
  logic [3:0]  b_fail_cnt;
  logic [31:0] b_wdata;

  sram_march_tester #(.NumWords(N)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(a_busy), .done_o(a_done),
    .pass_o(a_pass), .fail_addr_o(a_fail_addr), .fail_elem_o(a_fail_elem),
    .fail_cnt_o(a_fail_cnt), .sram_req_o(a_req), .sram_we_o(a_we), .sram_addr_o(a_addr),
    .sram_wdata_o(a_wdata), .sram_be_o(a_be), .sram_set_retentive_no(a_ret),
    .sram_rdata_i(rdata)
  );

  sram_march_tester #(.NumWords(N), .FailCntWidth(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(b_busy), .done_o(b_done),
    .pass_o(b_pass), .fail_addr_o(b_fail_addr), .fail_elem_o(b_fail_elem),
    .fail_cnt_o(b_fail_cnt), .sram_req_o(b_req), .sram_we_o(b_we), .sram_addr_o(b_addr),
    .sram_wdata_o(b_wdata), .sram_be_o(b_be), .sram_set_retentive_no(b_ret),
    .sram_rdata_i(rdata)
  );

  // Selected-instance view
  logic        m_busy, m_done, m_pass, m_req, m_we;
  logic [3:0]  m_addr, m_fail_addr;
  logic [2:0]  m_fail_elem;
  logic [15:0] m_fail_cnt;
  logic [31:0] m_wdata;
  assign m_busy      = sel ? b_busy : a_busy;
  assign m_done      = sel ? b_done : a_done;
  assign m_pass      = sel ? b_pass : a_pass;
  assign m_req       = sel ? b_req : a_req;
  assign m_we        = sel ? b_we : a_we;
  assign m_addr      = sel ? b_addr : a_addr;
  assign m_wdata     = sel ? b_wdata : a_wdata;
  assign m_fail_addr = sel ? b_fail_addr : a_fail_addr;
  assign m_fail_elem = sel ? b_fail_elem : a_fail_elem;
  assign m_fail_cnt  = sel ? {12'd0, b_fail_cnt} : a_fail_cnt;

  // Behavioural SRAM with stuck-at-0 bits applied on read
  logic [31:0] mem    [N];
  logic [31:0] stuck0 [N];
  always @(posedge clk) begin
    if (m_req) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      rdata <= mem[m_addr] & ~stuck0[m_addr];
    end
  end

  // Request trace: {we, addr, wdata-if-write}
  bit rec = 1'b0;
  logic [36:0] trace_q [$];
  logic [36:0] exp_q   [$];
  always @(negedge clk) begin
    if (rec && m_req) trace_q.push_back({m_we, m_addr, (m_we ? m_wdata : 32'd0)});
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference March C-: element table of read value / write value (-1 = none).
  task automatic model(input int maxcnt, output int cnt, output int faddr, output int felem);
    int rdv [6] = '{-1, 0, 1, 0, 1, 0};
    int wrv [6] = '{0, 1, 0, 1, 0, -1};
    logic [31:0] m [N];
    logic [31:0] want, got;
    int a;
    cnt = 0; faddr = 0; felem = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) m[i] = 32'd0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (rdv[e] >= 0) begin
          want = (rdv[e] == 1) ? 32'hFFFF_FFFF : 32'd0;
          got  = m[a] & ~stuck0[a];
          exp_q.push_back({1'b0, 4'(a), 32'd0});
          if (got !== want) begin
            if (cnt == 0) begin faddr = a; felem = e; end
            if (cnt < maxcnt) cnt++;
          end
        end
        if (wrv[e] >= 0) begin
          m[a] = (wrv[e] == 1) ? 32'hFFFF_FFFF : 32'd0;
          exp_q.push_back({1'b1, 4'(a), m[a]});
        end
      end
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) stuck0[i] = 32'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // Counts negedges with busy high; bounded so a stuck DUT cannot hang the run.
  task automatic wait_idle(output int cyc, output bit ok);
    cyc = 0;
    while (m_busy && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    ok = !m_busy;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({a_busy, a_done, a_pass, a_req, a_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000", {a_busy, a_done, a_pass, a_req, a_we});
    end
    n_checks++;
    if ({a_fail_cnt, a_fail_addr, a_fail_elem, a_addr, a_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got cnt=%0h addr=%0h elem=%0h saddr=%0h wdata=%0h required 0",
               a_fail_cnt, a_fail_addr, a_fail_elem, a_addr, a_wdata);
    end
    n_checks++;
    if (a_be !== 4'hF || a_ret !== 1'b1 || b_be !== 4'hF || b_ret !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_const: got be=%h/%h ret=%b/%b required F/F 1/1", a_be, b_be, a_ret,
               b_ret);
    end
  endtask

  task automatic test_clean();
    int cyc, cnt, fa, fe, bad;
    bit ok;
    sel = 1'b0; clear_faults();
    model(65535, cnt, fa, fe);
    trace_q.delete(); rec = 1'b1;
    pulse_start();
    wait_idle(cyc, ok);
    rec = 1'b0;
    n_checks++;
    if (!ok || cyc != 10 * N + 1) begin
      n_fail++; $display("FAIL clean_busy: got %0d cycles required %0d", cyc, 10 * N + 1);
    end
    n_checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_fail_cnt !== 16'(cnt)) begin
      n_fail++;
      $display("FAIL clean_result: got done=%b pass=%b cnt=%0d required 1 1 %0d", m_done, m_pass,
               m_fail_cnt, cnt);
    end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++)
      if (bad < 0 && trace_q[i] !== exp_q[i]) bad = i;
    n_checks++;
    if (trace_q.size() != exp_q.size() || bad >= 0) begin
      n_fail++;
      $display("FAIL clean_trace: got len=%0d first_diff=%0d required len=%0d no diff",
               trace_q.size(), bad, exp_q.size());
    end
  endtask

  task automatic test_stuck_bit();
    int cyc, cnt, fa, fe;
    bit ok;
    sel = 1'b0; clear_faults();
    stuck0[7] = 32'h0000_0020;
    model(65535, cnt, fa, fe);
    pulse_start();
    wait_idle(cyc, ok);
    n_checks++;
    if (!ok || m_done !== 1'b1 || m_pass !== 1'b0) begin
      n_fail++; $display("FAIL stuck_verdict: got done=%b pass=%b required 1 0", m_done, m_pass);
    end
    n_checks++;
    if (m_fail_cnt !== 16'(cnt) || m_fail_addr !== 4'(fa) || m_fail_elem !== 3'(fe)) begin
      n_fail++;
      $display("FAIL stuck_fields: got cnt=%0d addr=%0d elem=%0d required %0d %0d %0d",
               m_fail_cnt, m_fail_addr, m_fail_elem, cnt, fa, fe);
    end
  endtask

  task automatic test_saturate();
    int cyc, cnt, fa, fe;
    bit ok;
    sel = 1'b1;
    for (int i = 0; i < N; i++) stuck0[i] = 32'hFFFF_FFFF;
    model(15, cnt, fa, fe);
    pulse_start();
    wait_idle(cyc, ok);
    n_checks++;
    if (!ok || cyc != 10 * N + 1 || m_pass !== 1'b0 || m_done !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_verdict: got cyc=%0d done=%b pass=%b required %0d 1 0", cyc, m_done,
               m_pass, 10 * N + 1);
    end
    n_checks++;
    if (m_fail_cnt !== 16'(cnt) || m_fail_addr !== 4'(fa) || m_fail_elem !== 3'(fe)) begin
      n_fail++;
      $display("FAIL sat_fields: got cnt=%0d addr=%0d elem=%0d required %0d %0d %0d",
               m_fail_cnt, m_fail_addr, m_fail_elem, cnt, fa, fe);
    end
    clear_faults();
    sel = 1'b0;
  endtask

  task automatic test_start_held();
    int cyc, cnt, fa, fe;
    bit ok;
    sel = 1'b0; clear_faults();
    stuck0[3] = 32'h8000_0000;
    model(65535, cnt, fa, fe);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk);
    wait_idle(cyc, ok);
    n_checks++;
    if (!ok || cyc != 10 * N + 1 || m_done !== 1'b1 || m_fail_cnt !== 16'(cnt)) begin
      n_fail++;
      $display("FAIL held_first: got cyc=%0d done=%b cnt=%0d required %0d 1 %0d", cyc, m_done,
               m_fail_cnt, 10 * N + 1, cnt);
    end
    @(negedge clk);
    n_checks++;
    if (m_busy !== 1'b1 || m_done !== 1'b0 || m_fail_cnt !== 16'd0 || m_fail_addr !== 4'd0 ||
        m_fail_elem !== 3'd0) begin
      n_fail++;
      $display("FAIL held_restart: got busy=%b done=%b cnt=%0d addr=%0d elem=%0d required 1 0 0 0 0",
               m_busy, m_done, m_fail_cnt, m_fail_addr, m_fail_elem);
    end
    start_a = 1'b0;
    wait_idle(cyc, ok);
    n_checks++;
    if (!ok || m_fail_cnt !== 16'(cnt) || m_fail_addr !== 4'(fa)) begin
      n_fail++;
      $display("FAIL held_second: got cnt=%0d addr=%0d required %0d %0d", m_fail_cnt,
               m_fail_addr, cnt, fa);
    end
    clear_faults();
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit ok;
    sel = 1'b0; clear_faults();
    pulse_start();
    repeat (49) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_busy, a_done, a_pass, a_req, a_we} !== 5'b0 || a_fail_cnt !== 16'd0 ||
        a_addr !== 4'd0 || a_be !== 4'hF || a_ret !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_outputs: got flags=%b cnt=%0d addr=%0d be=%h ret=%b required 0 0 0 F 1",
               {a_busy, a_done, a_pass, a_req, a_we}, a_fail_cnt, a_addr, a_be, a_ret);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_req !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_next: got req=%b busy=%b required 0 0", a_req, a_busy);
    end
    pulse_start();
    wait_idle(cyc, ok);
    n_checks++;
    if (!ok || cyc != 10 * N + 1 || m_done !== 1'b1 || m_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rerun: got cyc=%0d done=%b pass=%b required %0d 1 1", cyc, m_done,
               m_pass, 10 * N + 1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, cnt, fa, fe;
    bit ok;
    logic [36:0] first [$];
    sel = 1'b0; clear_faults();
    model(65535, cnt, fa, fe);
    trace_q.delete(); rec = 1'b1;
    pulse_start();
    wait_idle(cyc, ok);
    rec = 1'b0;
    first = trace_q;
    trace_q.delete(); rec = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_checks++;
    if (m_busy !== 1'b1 || m_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_handover: got busy=%b done=%b required 1 0", m_busy, m_done);
    end
    wait_idle(cyc, ok);
    rec = 1'b0;
    n_checks++;
    if (!ok || cyc != 10 * N + 1 || trace_q != first || trace_q != exp_q) begin
      n_fail++;
      $display("FAIL b2b_trace: got cyc=%0d len=%0d/%0d required %0d identical traces", cyc,
               first.size(), trace_q.size(), 10 * N + 1);
    end
    n_checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1) begin
      n_fail++; $display("FAIL b2b_result: got done=%b pass=%b required 1 1", m_done, m_pass);
    end
  endtask

  task automatic test_random_faults();
    int cyc, cnt, fa, fe, nf, a;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      sel = 1'($urandom_range(0, 1));
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        a = $urandom_range(0, N - 1);
        stuck0[a] = stuck0[a] | (32'd1 << $urandom_range(0, 31));
      end
      model(sel ? 15 : 65535, cnt, fa, fe);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_start();
      wait_idle(cyc, ok);
      n_checks++;
      if (!ok || m_done !== 1'b1 || m_pass !== (cnt == 0) || m_fail_cnt !== 16'(cnt) ||
          m_fail_addr !== 4'(fa) || m_fail_elem !== 3'(fe)) begin
        n_fail++;
        $display("FAIL rand_%0d: got done=%b pass=%b cnt=%0d addr=%0d elem=%0d required 1 %b %0d %0d %0d",
                 it, m_done, m_pass, m_fail_cnt, m_fail_addr, m_fail_elem, (cnt == 0), cnt, fa,
                 fe);
      end
    end
    clear_faults();
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_clean();
    test_stuck_bit();
    test_saturate();
    test_start_held();
    test_mid_reset();
    test_back_to_back();
    test_random_faults();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
